// File: rtl/wide_bus_beat_assembler.sv
// Packs NBEATS narrow beats into one wide word behind a registered valid/ready output.
// Define WIDE_BUS_ASM_REDUCE_EN to add per-beat accumulated AND/OR/XOR reductions of the word.
module wide_bus_beat_assembler #(
    parameter int WIDE_W = 256,
    parameter int BEAT_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [BEAT_W-1:0]                    in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDE_W-1:0]                    out_data,
    output logic [$clog2(WIDE_W/BEAT_W):0]       out_beats,
    output logic                                 out_short
`ifdef WIDE_BUS_ASM_REDUCE_EN
    ,
    output logic                                 red_and,
    output logic                                 red_or,
    output logic                                 red_xor
`endif
);

    localparam int NBEATS = WIDE_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS) + 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDE_W-1:0]  r_word;
    logic [CNT_W-1:0]   r_count;
    logic               r_short;

    logic w_accept;
    logic w_full;
    logic w_close;
    logic w_release;

    assign w_accept  = in_valid && (r_state == FILL);
    assign w_full    = (r_count == CNT_W'(NBEATS - 1));
    assign w_close   = w_accept && (w_full || in_last);
    assign w_release = (r_state == HOLD) && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_close)   w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // NOTE: the word register is reset because unfilled slots of a short frame must read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_count <= '0;
            r_short <= 1'b0;
        end else if (w_release) begin
            r_word  <= '0;
            r_count <= '0;
            r_short <= 1'b0;
        end else if (w_accept) begin
            for (int k = 0; k < NBEATS; k++) begin
                if (r_count == CNT_W'(k)) r_word[k*BEAT_W +: BEAT_W] <= in_data;
            end
            r_count <= r_count + CNT_W'(1);
            if (w_close) r_short <= !w_full;
        end
    end

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_word;
    assign out_beats = r_count;
    assign out_short = r_short;

`ifdef WIDE_BUS_ASM_REDUCE_EN
    logic r_acc_and;
    logic r_acc_or;
    logic r_acc_xor;
    logic r_red_and;
    logic r_red_or;
    logic r_red_xor;

    // Zero-filled slots of a short word pull the AND low, so it is only kept on a full close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_and <= 1'b1;
            r_acc_or  <= 1'b0;
            r_acc_xor <= 1'b0;
            r_red_and <= 1'b0;
            r_red_or  <= 1'b0;
            r_red_xor <= 1'b0;
        end else if (w_release) begin
            r_acc_and <= 1'b1;
            r_acc_or  <= 1'b0;
            r_acc_xor <= 1'b0;
            r_red_and <= 1'b0;
            r_red_or  <= 1'b0;
            r_red_xor <= 1'b0;
        end else if (w_close) begin
            r_red_and <= r_acc_and & (&in_data) & w_full;
            r_red_or  <= r_acc_or | (|in_data);
            r_red_xor <= r_acc_xor ^ (^in_data);
        end else if (w_accept) begin
            r_acc_and <= r_acc_and & (&in_data);
            r_acc_or  <= r_acc_or | (|in_data);
            r_acc_xor <= r_acc_xor ^ (^in_data);
        end
    end

    assign red_and = r_red_and;
    assign red_or  = r_red_or;
    assign red_xor = r_red_xor;
`endif

endmodule

// File: tb/tb_wide_bus_beat_assembler.sv
// Self-checking bench for wide_bus_beat_assembler: directed frames plus randomized frames
// compared against a queue-based model of the assembled word.
module tb_wide_bus_beat_assembler;

    localparam int WIDE_W = 256;
    localparam int BEAT_W = 32;
    localparam int NBEATS = WIDE_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS) + 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              out_ready = 1'b1;
    logic [BEAT_W-1:0] in_data   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDE_W-1:0] out_data;
    logic [CNT_W-1:0]  out_beats;
    logic              out_short;
`ifdef WIDE_BUS_ASM_REDUCE_EN
    logic              red_and;
    logic              red_or;
    logic              red_xor;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [BEAT_W-1:0] q_beats[$];
    bit                q_last;
    logic [BEAT_W-1:0] held;

    wide_bus_beat_assembler #(.WIDE_W(WIDE_W), .BEAT_W(BEAT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_short (out_short)
`ifdef WIDE_BUS_ASM_REDUCE_EN
        ,
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDE_W-1:0] obs, input logic [WIDE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k of the frame occupies bits [k*BEAT_W +: BEAT_W]; everything else is zero.
    function automatic logic [WIDE_W-1:0] model_word();
        logic [WIDE_W-1:0] w = '0;
        for (int k = 0; k < q_beats.size(); k++) w = w | (WIDE_W'(q_beats[k]) << (k * BEAT_W));
        return w;
    endfunction

    function automatic bit model_short();
        return q_last && (q_beats.size() < NBEATS);
    endfunction

    // Offers every beat of q_beats, with random idle gaps carrying junk that must be ignored.
    task automatic drive_frame(input int gap_max, input bit ready_now);
        out_ready = ready_now;
        for (int i = 0; i < q_beats.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = q_beats[i];
            in_last  = q_last && (i == q_beats.size() - 1);
            check("in_ready_fill", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_hold(input string tag);
        logic [WIDE_W-1:0] w;
        w = model_word();
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_data"},  out_data,  w);
        check({tag, "_out_beats"}, out_beats, WIDE_W'(q_beats.size()));
        check({tag, "_out_short"}, out_short, WIDE_W'(model_short()));
`ifdef WIDE_BUS_ASM_REDUCE_EN
        check({tag, "_red_and"}, red_and, WIDE_W'(&w));
        check({tag, "_red_or"},  red_or,  WIDE_W'(|w));
        check({tag, "_red_xor"}, red_xor, WIDE_W'(^w));
`endif
    endtask

    task automatic release_word(input int stall);
        repeat (stall) begin
            @(negedge clk);
            check_hold("stall");
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready",  in_ready,  1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready",  in_ready,  1);
        check("rel_out_valid", out_valid, 0);
        check("rel_out_beats", out_beats, 0);
        check("rel_out_short", out_short, 0);
`ifdef WIDE_BUS_ASM_REDUCE_EN
        check("rel_red_and", red_and, 0);
        check("rel_red_or",  red_or,  0);
        check("rel_red_xor", red_xor, 0);
`endif

        // 1: full frame of 1..8, no in_last
        q_beats = {};
        for (int i = 1; i <= NBEATS; i++) q_beats.push_back(BEAT_W'(i));
        q_last = 0;
        drive_frame(0, 1);
        check_hold("t1");
        release_word(0);

        // 2: three all-ones beats closed early
        q_beats = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        q_last  = 1;
        drive_frame(0, 1);
        check_hold("t2");
        release_word(0);

        // 3: back-pressure with a beat offered during HOLD; it becomes the next word
        q_beats = {};
        for (int i = 0; i < NBEATS; i++) q_beats.push_back($urandom);
        q_last = 0;
        drive_frame(0, 0);
        check_hold("t3");
        held     = $urandom;
        in_valid = 1'b1;
        in_data  = held;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_hold("t3_stall");
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_rel_out_valid", out_valid, 0);
        check("t3_rel_in_ready",  in_ready,  1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        q_beats  = {held};
        q_last   = 1;
        check_hold("t3_held");
        release_word(0);

        // 4: reset after four accepted beats, then a clean A5 frame
        q_beats = {};
        for (int i = 0; i < 4; i++) q_beats.push_back($urandom | 32'h1);
        q_last = 0;
        drive_frame(0, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_out_data",  out_data,  0);
        check("t4_rst_out_beats", out_beats, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q_beats = {};
        for (int i = 0; i < NBEATS; i++) q_beats.push_back(32'hA5A5_A5A5);
        q_last = 0;
        drive_frame(0, 1);
        check_hold("t4");
        release_word(0);

        // 5: single beat with in_last
        q_beats = {32'h8000_0000};
        q_last  = 1;
        drive_frame(0, 1);
        check_hold("t5");
        release_word(0);

        // 6: all-ones full frame with idle gaps, in_last on the last beat (normal close)
        q_beats = {};
        for (int i = 0; i < NBEATS; i++) q_beats.push_back(32'hFFFF_FFFF);
        q_last = 1;
        drive_frame(3, 1);
        check_hold("t6");
        release_word(0);

        // Randomized frames: length, close type, gaps and output stalls
        for (int f = 0; f < 30; f++) begin
            int n;
            int stall;
            n     = $urandom_range(NBEATS, 1);
            stall = $urandom_range(3, 0);
            q_beats = {};
            for (int i = 0; i < n; i++) q_beats.push_back(($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom);
            q_last = (n < NBEATS) ? 1'b1 : 1'($urandom);
            drive_frame(2, stall == 0);
            check_hold("rnd");
            release_word(stall);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
